// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl -- staged reset release sequencer.
//
// Holds all domains in reset for HOLD_CYC cycles, then releases them one at a
// time starting with domain 0. Each released domain must acknowledge within
// ACK_TIMEOUT cycles, and consecutive releases are separated by GAP_CYC
// cycles. When every domain is out of reset and acknowledging, the
// controller sits in DONE and watches for any ack to drop. A timeout or a
// dropped ack pulls every domain back into reset and parks in ERROR until
// software asks for a re-run.
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   SW_RST_REQ  one-cycle request to restart the sequence (highest priority)
//   DOM_ACK     per-domain "out of reset" acknowledge, synchronous to CLK
//   DOM_RST_N   per-domain active-low reset, bit 0 released first
//   BUSY        sequence in progress (ASSERT / WAIT_ACK / GAP)
//   SEQ_DONE    all domains released and healthy
//   SEQ_ERR     controller is in ERROR
//   ERR_DOM     index of the domain that caused the error

// Per-domain release flop. Once set, the reset stays released until the
// controller clears all domains together.
module rst_seq_dom (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic ack,
  output logic rst_n,
  output logic ack_lost
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rst_n <= 1'b0;
    else if (clr) rst_n <= 1'b0;
    else if (set) rst_n <= 1'b1;
  end

  // Only meaningful for a released domain; unreleased domains never flag.
  assign ack_lost = rst_n & ~ack;

endmodule

module rst_seq_ctrl #(
  parameter int NUM_DOM     = 3,
  parameter int HOLD_CYC    = 4,
  parameter int GAP_CYC     = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic                                            SW_RST_REQ,
  input  logic [NUM_DOM-1:0]                              DOM_ACK,
  output logic [NUM_DOM-1:0]                              DOM_RST_N,
  output logic                                            BUSY,
  output logic                                            SEQ_DONE,
  output logic                                            SEQ_ERR,
  output logic [((NUM_DOM > 1) ? $clog2(NUM_DOM) : 1)-1:0] ERR_DOM
);

  localparam int IW   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int HG   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CMAX = (HG > ACK_TIMEOUT) ? HG : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt, idx_inc;
  logic [NUM_DOM-1:0]   rel_set;
  logic                 rel_clr;
  logic [NUM_DOM-1:0]   ack_lost;
  logic [IW-1:0]        lost_idx;
  logic                 any_lost;
  logic                 ack_cur;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic [IW-1:0]        err_dom_nxt;

  // Per-domain release flops
  genvar g;
  generate
    for (g = 0; g < NUM_DOM; g++) begin : g_dom
      rst_seq_dom u_dom (
        .clk      (CLK),
        .rst      (RST),
        .set      (rel_set[g]),
        .clr      (rel_clr),
        .ack      (DOM_ACK[g]),
        .rst_n    (DOM_RST_N[g]),
        .ack_lost (ack_lost[g])
      );
    end
  endgenerate

  assign idx_inc  = idx + IW'(1);
  assign ack_cur  = DOM_ACK[idx];
  assign any_lost = |ack_lost;

  // Lowest-index domain whose ack dropped; scan high to low so the lowest wins.
  always_comb begin
    lost_idx = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (ack_lost[i]) lost_idx = IW'(i);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    rel_set     = '0;
    rel_clr     = 1'b0;
    busy_nxt    = BUSY;
    done_nxt    = SEQ_DONE;
    err_nxt     = SEQ_ERR;
    err_dom_nxt = ERR_DOM;

    if (SW_RST_REQ) begin
      // Restart beats every other condition, including a same-cycle ack.
      state_nxt = S_ASSERT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rel_clr   = 1'b1;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            state_nxt  = S_WAIT_ACK;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            rel_set[0] = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        S_WAIT_ACK: begin
          // Ack is tested before timeout so a last-cycle ack still counts.
          if (ack_cur) begin
            cnt_nxt = '0;
            if (idx == IW'(NUM_DOM - 1)) begin
              state_nxt = S_DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_GAP;
            end
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            state_nxt   = S_ERROR;
            cnt_nxt     = '0;
            rel_clr     = 1'b1;
            busy_nxt    = 1'b0;
            err_nxt     = 1'b1;
            err_dom_nxt = idx;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            state_nxt = S_WAIT_ACK;
            cnt_nxt   = '0;
            idx_nxt   = idx_inc;
            rel_set   = NUM_DOM'(1) << idx_inc;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        S_DONE: begin
          if (any_lost) begin
            state_nxt   = S_ERROR;
            cnt_nxt     = '0;
            rel_clr     = 1'b1;
            done_nxt    = 1'b0;
            err_nxt     = 1'b1;
            err_dom_nxt = lost_idx;
          end
        end

        S_ERROR: begin
          // Parked until software restart or hard reset.
        end

        default: begin
          state_nxt = S_ASSERT;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          rel_clr   = 1'b1;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      BUSY     <= 1'b1;
      SEQ_DONE <= 1'b0;
      SEQ_ERR  <= 1'b0;
      ERR_DOM  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      BUSY     <= busy_nxt;
      SEQ_DONE <= done_nxt;
      SEQ_ERR  <= err_nxt;
      ERR_DOM  <= err_dom_nxt;
    end
  end

endmodule
